// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates and colour, measures
// line/frame geometry and declares lock after enough consecutive matching frames.
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        valid,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_data,
    output logic        frame_start,
    output logic        locked,
    output logic        err,
    output logic [9:0]  meas_htotal,
    output logic [9:0]  meas_hactive,
    output logic [9:0]  meas_vtotal,
    output logic [9:0]  meas_vactive
);

    localparam logic [9:0] H_TOTAL_C  = 10'(H_TOTAL);
    localparam logic [9:0] H_ACTIVE_C = 10'(H_ACTIVE);
    localparam logic [9:0] V_TOTAL_C  = 10'(V_TOTAL);
    localparam logic [9:0] V_ACTIVE_C = 10'(V_ACTIVE);
    localparam logic [3:0] LOCK_C     = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  match_cnt;
    logic [3:0]  match_nxt;

    logic        hs_p0;
    logic        vs_p0;
    logic        vld_p0;
    logic [11:0] rgb_p0;
    logic        hs_p1;
    logic        vs_p1;
    logic        vld_p1;

    logic [9:0]  hcnt;
    logic [9:0]  hact;
    logic [9:0]  vtot_cnt;
    logic [9:0]  vact_cnt;
    logic        line_act;
    logic [9:0]  x_cnt;
    logic [9:0]  y_cnt;

    logic        hfall;
    logic        vfall;
    logic        vldfall;
    logic [9:0]  vtot_line;
    logic [9:0]  vact_line;
    logic [9:0]  htot_cur;
    logic [9:0]  hact_cur;
    logic        frame_match;
    logic        x_full;
    logic        h_bad;
    logic        err_nxt;
    logic        pix_take;

    // Only the low colour nibbles carry information.
    logic        unused_hi;
    assign unused_hi = ^{vga_r[7:4], vga_g[7:4], vga_b[7:4]};

    assign hfall   = hs_p1 & ~hs_p0;
    assign vfall   = vs_p1 & ~vs_p0;
    assign vldfall = vld_p1 & ~vld_p0;

    // A line ending on the same edge as vsync is counted before the frame totals are taken.
    assign vtot_line = hfall ? sat_inc(vtot_cnt) : vtot_cnt;
    assign vact_line = (hfall && line_act) ? sat_inc(vact_cnt) : vact_cnt;
    assign htot_cur  = hfall ? hcnt : meas_htotal;
    assign hact_cur  = vldfall ? hact : meas_hactive;

    assign frame_match = (htot_cur == H_TOTAL_C) && (hact_cur == H_ACTIVE_C) &&
                         (vtot_line == V_TOTAL_C) && (vact_line == V_ACTIVE_C);
    assign x_full      = (x_cnt == H_ACTIVE_C);
    assign h_bad       = hfall && (hcnt != H_TOTAL_C);

    always_ff @(posedge pclk) begin
        if (!reset) begin
            state     <= SEARCH;
            match_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            match_cnt <= match_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        match_nxt = match_cnt;
        case (state)
            SEARCH: begin
                match_nxt = 4'd0;
                if (vfall) state_nxt = MEASURE;
            end
            MEASURE: begin
                if (vfall) begin
                    if (frame_match) begin
                        match_nxt = match_cnt + 4'd1;
                        if (match_cnt + 4'd1 == LOCK_C) state_nxt = LOCKED;
                    end else begin
                        match_nxt = 4'd0;
                    end
                end
            end
            LOCKED: begin
                // A failing vsync edge doubles as the first edge of a new search.
                if (vfall && !frame_match) begin
                    state_nxt = MEASURE;
                    match_nxt = 4'd0;
                end else if (h_bad) begin
                    state_nxt = SEARCH;
                    match_nxt = 4'd0;
                end
            end
            default: begin
                state_nxt = SEARCH;
                match_nxt = 4'd0;
            end
        endcase
    end

    always_comb begin
        locked   = (state == LOCKED);
        err_nxt  = (state == LOCKED) &&
                   ((vfall && !frame_match) || h_bad || (vld_p0 && x_full));
        pix_take = (state == LOCKED) && vld_p0 && !x_full;
    end

    always_ff @(posedge pclk) begin
        if (!reset) begin
            hs_p0        <= 1'b0;
            vs_p0        <= 1'b0;
            vld_p0       <= 1'b0;
            rgb_p0       <= 12'd0;
            hs_p1        <= 1'b0;
            vs_p1        <= 1'b0;
            vld_p1       <= 1'b0;
            hcnt         <= 10'd0;
            hact         <= 10'd0;
            vtot_cnt     <= 10'd0;
            vact_cnt     <= 10'd0;
            line_act     <= 1'b0;
            x_cnt        <= 10'd0;
            y_cnt        <= 10'd0;
            meas_htotal  <= 10'd0;
            meas_hactive <= 10'd0;
            meas_vtotal  <= 10'd0;
            meas_vactive <= 10'd0;
            pix_valid    <= 1'b0;
            pix_x        <= 10'd0;
            pix_y        <= 10'd0;
            pix_data     <= 12'd0;
            frame_start  <= 1'b0;
            err          <= 1'b0;
        end else begin
            // Input registers, then a second sync copy for edge detection
            hs_p0  <= hsync;
            vs_p0  <= vsync;
            vld_p0 <= valid;
            rgb_p0 <= {vga_r[3:0], vga_g[3:0], vga_b[3:0]};
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            vld_p1 <= vld_p0;

            // Geometry measurement and coordinate tracking from the edge-detected stream
            if (hfall) begin
                meas_htotal <= hcnt;
                hcnt        <= 10'd1;
            end else begin
                hcnt <= sat_inc(hcnt);
            end

            if (vldfall) begin
                meas_hactive <= hact;
                hact         <= 10'd0;
            end else if (vld_p0) begin
                hact <= sat_inc(hact);
            end

            if (hfall) line_act <= vld_p0;
            else if (vld_p0) line_act <= 1'b1;

            if (vfall) begin
                meas_vtotal  <= vtot_line;
                meas_vactive <= vact_line;
                vtot_cnt     <= 10'd0;
                vact_cnt     <= 10'd0;
            end else begin
                vtot_cnt <= vtot_line;
                vact_cnt <= vact_line;
            end

            if (vldfall) x_cnt <= 10'd0;
            else if (vld_p0 && !x_full) x_cnt <= x_cnt + 10'd1;

            if (vfall) y_cnt <= 10'd0;
            else if (vldfall) y_cnt <= sat_inc(y_cnt);

            // Output registers
            pix_valid <= pix_take;
            if (pix_take) begin
                pix_x    <= x_cnt;
                pix_y    <= y_cnt;
                pix_data <= rgb_p0;
            end
            frame_start <= vfall;
            err         <= err_nxt;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Randomized scoreboard bench for vga_sync_decoder on a scaled-down video mode,
// with a frame-level reference model predicting lock, errors and captured pixels.
module tb_vga_sync_decoder;

    localparam int H_T       = 48;
    localparam int H_A       = 24;
    localparam int V_T       = 20;
    localparam int V_A       = 12;
    localparam int LK        = 2;
    localparam int HS_W      = 6;
    localparam int HV_START  = 12;
    localparam int VS_L      = 2;
    localparam int ACT_FIRST = 4;
    localparam int ACT_LAST  = ACT_FIRST + V_A - 1;
    localparam int RST_C     = 4;

    logic        pclk;
    logic        reset;
    logic        hsync;
    logic        vsync;
    logic        valid;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [11:0] pix_data;
    logic        frame_start;
    logic        locked;
    logic        err;
    logic [9:0]  meas_htotal;
    logic [9:0]  meas_hactive;
    logic [9:0]  meas_vtotal;
    logic [9:0]  meas_vactive;

    vga_sync_decoder #(
        .H_TOTAL    (H_T),
        .H_ACTIVE   (H_A),
        .V_TOTAL    (V_T),
        .V_ACTIVE   (V_A),
        .LOCK_FRAMES(LK)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .hsync       (hsync),
        .vsync       (vsync),
        .valid       (valid),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_data    (pix_data),
        .frame_start (frame_start),
        .locked      (locked),
        .err         (err),
        .meas_htotal (meas_htotal),
        .meas_hactive(meas_hactive),
        .meas_vtotal (meas_vtotal),
        .meas_vactive(meas_vactive)
    );

    typedef struct {
        int          cyc;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] d;
    } pix_t;

    typedef struct {
        int cyc;
        bit lk;
        bit chk;
        int ht;
        int ha;
        int vt;
        int va;
    } frm_t;

    typedef struct {
        int cyc;
        int ht;
    } err_t;

    pix_t pq[$];
    frm_t fq[$];
    err_t eq[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    bit m_locked  = 0;
    bit m_started = 0;
    int m_run     = 0;
    bit prev_full = 0;
    int last_len  = 0;
    int f_lines   = 0;
    int f_act     = 0;
    bit rst_chk   = 0;

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input bit ok, input string name, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    task automatic check_all_zero(input string name);
        bit ok;
        ok = (pix_valid == 1'b0) && (pix_x == 10'd0) && (pix_y == 10'd0) &&
             (pix_data == 12'd0) && (frame_start == 1'b0) && (locked == 1'b0) &&
             (err == 1'b0) && (meas_htotal == 10'd0) && (meas_hactive == 10'd0) &&
             (meas_vtotal == 10'd0) && (meas_vactive == 10'd0);
        check(ok, name, $sformatf("got pv=%b x=%0d y=%0d d=%h fs=%b lk=%b err=%b meas=%0d/%0d/%0d/%0d, required all zero",
              pix_valid, pix_x, pix_y, pix_data, frame_start, locked, err,
              meas_htotal, meas_hactive, meas_vtotal, meas_vactive));
    endtask

    // Frame boundary: judge the frame that just ended from the geometry that was generated.
    task automatic frame_event();
        frm_t f;
        err_t e;
        bit   ok;
        bit   raise;
        ok    = (f_lines == V_T) && (f_act == V_A) && (last_len == H_T);
        raise = 0;
        if (m_locked) begin
            if (!ok) begin
                m_locked = 0;
                m_run    = 0;
                raise    = 1;
            end
            m_started = 1;
        end else if (!m_started) begin
            m_started = 1;
            m_run     = 0;
        end else begin
            m_run = ok ? m_run + 1 : 0;
            if (m_run >= LK) m_locked = 1;
        end
        f.cyc = cyc + 2;
        f.lk  = m_locked;
        f.chk = prev_full;
        f.ht  = last_len;
        f.ha  = H_A;
        f.vt  = f_lines;
        f.va  = f_act;
        fq.push_back(f);
        if (raise) begin
            e.cyc = cyc + 2;
            e.ht  = last_len;
            eq.push_back(e);
        end
        prev_full = 1;
    endtask

    task automatic line_event();
        err_t e;
        if (m_locked && last_len != H_T) begin
            m_locked  = 0;
            m_started = 0;
            m_run     = 0;
            e.cyc     = cyc + 2;
            e.ht      = last_len;
            eq.push_back(e);
        end
    endtask

    task automatic drive_frame(input int n_lines, input int a_last, input int stretch, input int rst_line);
        for (int ln = 0; ln < n_lines; ln++) begin
            int len;
            len = (ln == stretch) ? H_T + 1 : H_T;
            for (int c = 0; c < len; c++) begin
                bit   act;
                pix_t p;
                @(negedge pclk);
                if (rst_chk) begin
                    check_all_zero("midframe_reset");
                    rst_chk = 0;
                end
                reset = 1'b1;
                hsync = (c >= HS_W);
                vsync = (ln >= VS_L);
                act   = (ln >= ACT_FIRST) && (ln <= a_last) && (c >= HV_START) && (c < HV_START + H_A);
                valid = act;
                vga_r = 8'($urandom);
                vga_g = 8'($urandom);
                vga_b = 8'($urandom);
                if (act && ln == ACT_FIRST && c == HV_START) begin
                    vga_r[3:0] = 4'hA;
                    vga_g[3:0] = 4'h5;
                    vga_b[3:0] = 4'hC;
                end
                if (c == 0) begin
                    if (ln == 0) frame_event();
                    else line_event();
                end
                if (act && m_locked) begin
                    p.cyc = cyc + 2;
                    p.x   = 10'(c - HV_START);
                    p.y   = 10'(ln - ACT_FIRST);
                    p.d   = {vga_r[3:0], vga_g[3:0], vga_b[3:0]};
                    pq.push_back(p);
                end
                if (ln == rst_line && c == RST_C) begin
                    reset     = 1'b0;
                    m_locked  = 0;
                    m_started = 0;
                    m_run     = 0;
                    prev_full = 0;
                    rst_chk   = 1;
                end
            end
            last_len = len;
        end
        f_lines = n_lines;
        f_act   = a_last - ACT_FIRST + 1;
    endtask

    always @(negedge pclk) begin
        if (pix_valid === 1'b1) begin
            if (pq.size() == 0) begin
                check(0, "pix_unexpected", $sformatf("got pixel x=%0d y=%0d at cyc %0d, required none", pix_x, pix_y, cyc));
            end else begin
                pix_t p;
                p = pq.pop_front();
                check((p.cyc == cyc) && (pix_x == p.x) && (pix_y == p.y) && (pix_data == p.d), "pixel",
                      $sformatf("got x=%0d y=%0d d=%h cyc=%0d, required x=%0d y=%0d d=%h cyc=%0d",
                                pix_x, pix_y, pix_data, cyc, p.x, p.y, p.d, p.cyc));
            end
        end
        if (frame_start === 1'b1) begin
            if (fq.size() == 0) begin
                check(0, "frame_unexpected", $sformatf("got frame_start at cyc %0d, required none", cyc));
            end else begin
                frm_t f;
                bit   ok;
                f  = fq.pop_front();
                ok = (f.cyc == cyc) && (locked == f.lk);
                if (f.chk)
                    ok = ok && (int'(meas_htotal) == f.ht) && (int'(meas_hactive) == f.ha) &&
                         (int'(meas_vtotal) == f.vt) && (int'(meas_vactive) == f.va);
                check(ok, "frame",
                      $sformatf("got cyc=%0d lk=%b meas=%0d/%0d/%0d/%0d, required cyc=%0d lk=%b meas=%0d/%0d/%0d/%0d (checked=%b)",
                                cyc, locked, meas_htotal, meas_hactive, meas_vtotal, meas_vactive,
                                f.cyc, f.lk, f.ht, f.ha, f.vt, f.va, f.chk));
            end
        end
        if (err === 1'b1) begin
            if (eq.size() == 0) begin
                check(0, "err_unexpected", $sformatf("got err at cyc %0d, required none", cyc));
            end else begin
                err_t e;
                e = eq.pop_front();
                check((e.cyc == cyc) && (locked == 1'b0) && (int'(meas_htotal) == e.ht), "err",
                      $sformatf("got cyc=%0d lk=%b htotal=%0d, required cyc=%0d lk=0 htotal=%0d",
                                cyc, locked, meas_htotal, e.cyc, e.ht));
            end
        end
    end

    initial begin
        reset = 1'b0;
        hsync = 1'($urandom);
        vsync = 1'($urandom);
        valid = 1'($urandom);
        vga_r = 8'($urandom);
        vga_g = 8'($urandom);
        vga_b = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check_all_zero($sformatf("reset_hold_%0d", i));
            hsync = 1'($urandom);
            vsync = 1'($urandom);
            valid = 1'($urandom);
            vga_r = 8'($urandom);
            vga_g = 8'($urandom);
            vga_b = 8'($urandom);
        end
        reset = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        valid = 1'b0;
        repeat ($urandom_range(5, 20)) @(negedge pclk);

        // Initial lock, then a stretched line while locked, then recovery
        repeat (3) drive_frame(V_T, ACT_LAST, -1, -1);
        drive_frame(V_T, ACT_LAST, $urandom_range(3, 17), -1);
        repeat (2) drive_frame(V_T, ACT_LAST, -1, -1);
        // Locked frame interrupted by a one-cycle reset
        drive_frame(V_T, ACT_LAST, -1, $urandom_range(2, 18));
        // One clean frame, one with an extra active line, then relock
        drive_frame(V_T, ACT_LAST, -1, -1);
        drive_frame(V_T, ACT_LAST + 1, -1, -1);
        repeat (3) drive_frame(V_T, ACT_LAST, -1, -1);
        drive_frame(1, ACT_LAST, -1, -1);

        @(negedge pclk);
        hsync = 1'b1;
        vsync = 1'b1;
        valid = 1'b0;
        repeat (10) @(negedge pclk);

        check(pq.size() == 0, "pixels_left", $sformatf("got %0d pending pixels, required 0", pq.size()));
        check(fq.size() == 0, "frames_left", $sformatf("got %0d pending frame_start, required 0", fq.size()));
        check(eq.size() == 0, "errs_left", $sformatf("got %0d pending err, required 0", eq.size()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
